counter_nx: RTL and testbench

Parametrised, fully synchronous up/down/step/load counter built from a chain of 4-bit slices. It is the next generation of the team's cascaded 32-bit counter. All slices share one clock; carries propagate combinationally between slices, so there are no derived or rippled clocks. It adds width scaling, an optional saturating mode and single-cycle status pulses, and is the standard counter for timers and address generators in the datapath.

---
 rtl/counter_pkg.sv | 15 +
 rtl/counter_slice.sv | 19 +
 rtl/counter_nx.sv | 116 +++++++++++
 tb/tb_counter_nx.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// counter_pkg: shared definitions for the cascaded nibble counter.
//   SLICE_W - width of one adder slice in the carry chain
//   mode_e  - counter operation selected by the 2-bit mode input
package counter_pkg;

  localparam int SLICE_W = 4;

  typedef enum logic [1:0] {
    MODE_UP1  = 2'b00,
    MODE_DN1  = 2'b01,
    MODE_UP3  = 2'b10,
    MODE_LOAD = 2'b11
  } mode_e;

endpackage

// File: rtl/counter_slice.sv
// counter_slice: combinational SLICE_W-bit adder, one link of the carry chain.
//   i_a    - current slice value
//   i_b    - step digit for this slice
//   i_cin  - carry from the slice below
//   o_sum  - next slice value
//   o_cout - carry into the slice above
module counter_slice
  import counter_pkg::*;
(
  input  logic [SLICE_W-1:0] i_a,
  input  logic [SLICE_W-1:0] i_b,
  input  logic               i_cin,
  output logic [SLICE_W-1:0] o_sum,
  output logic               o_cout
);

  assign {o_cout, o_sum} = {1'b0, i_a} + {1'b0, i_b} + {{SLICE_W{1'b0}}, i_cin};

endmodule

// File: rtl/counter_nx.sv
// counter_nx: synchronous up/down/step-3/load counter built from NIBBLES
// chained 4-bit slices, with optional saturation and registered status pulses.
//   clk    - single clock, rising edge
//   reset  - asynchronous active-low reset
//   enable - count/load qualifier
//   mode   - 00 up 1, 01 down 1, 10 up 3, 11 load D
//   D      - parallel load value
//   Q      - registered count
//   rco    - one-cycle wrap/clamp pulse aligned with Q
//   load   - one-cycle load pulse aligned with Q
module counter_nx
  import counter_pkg::*;
#(
  parameter int NIBBLES  = 8,
  parameter bit SATURATE = 1'b0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [1:0]           mode,
  input  logic [4*NIBBLES-1:0] D,
  output logic [4*NIBBLES-1:0] Q,
  output logic                 rco,
  output logic                 load
);

  localparam int W = SLICE_W * NIBBLES;

  logic [W-1:0]       r_q;
  logic               r_rco;
  logic               r_load;

  mode_e              w_mode;
  logic [SLICE_W-1:0] w_step_lo;
  logic [SLICE_W-1:0] w_step_hi;
  logic [NIBBLES:0]   w_carry;
  logic [W-1:0]       w_sum;
  logic               w_is_dn;
  logic               w_limit;
  logic [W-1:0]       w_q_next;
  logic               w_rco_next;
  logic               w_load_next;

  assign w_mode = mode_e'(mode);

  // Decrement is an add of all-ones across every slice; upward steps only
  // put a non-zero digit into the lowest slice.
  always_comb begin
    w_step_lo = '0;
    w_step_hi = '0;
    case (w_mode)
      MODE_UP1: w_step_lo = SLICE_W'(1);
      MODE_UP3: w_step_lo = SLICE_W'(3);
      MODE_DN1: begin
        w_step_lo = '1;
        w_step_hi = '1;
      end
      default: ;
    endcase
  end

  assign w_carry[0] = 1'b0;

  generate
    for (genvar gi = 0; gi < NIBBLES; gi++) begin : g_slice
      counter_slice u_slice (
        .i_a    (r_q[gi*SLICE_W +: SLICE_W]),
        .i_b    ((gi == 0) ? w_step_lo : w_step_hi),
        .i_cin  (w_carry[gi]),
        .o_sum  (w_sum[gi*SLICE_W +: SLICE_W]),
        .o_cout (w_carry[gi+1])
      );
    end
  endgenerate

  // Top carry-out means overflow when counting up; for the all-ones add of a
  // decrement, a missing carry-out means the count borrowed below zero.
  assign w_is_dn = (w_mode == MODE_DN1);
  assign w_limit = w_is_dn ? ~w_carry[NIBBLES] : w_carry[NIBBLES];

  always_comb begin
    w_q_next    = r_q;
    w_rco_next  = 1'b0;
    w_load_next = 1'b0;
    if (enable) begin
      if (w_mode == MODE_LOAD) begin
        w_q_next    = D;
        w_load_next = 1'b1;
      end else begin
        w_rco_next = w_limit;
        if (SATURATE && w_limit) begin
          w_q_next = w_is_dn ? '0 : '1;
        end else begin
          w_q_next = w_sum;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_q    <= '0;
      r_rco  <= 1'b0;
      r_load <= 1'b0;
    end else begin
      r_q    <= w_q_next;
      r_rco  <= w_rco_next;
      r_load <= w_load_next;
    end
  end

  assign Q    = r_q;
  assign rco  = r_rco;
  assign load = r_load;

endmodule

// File: tb/tb_counter_nx.sv
// tb_counter_nx: checks a 32-bit wrapping instance and an 8-bit saturating
// instance (sharing clock, reset, enable and mode) against an arithmetic model.
module tb_counter_nx;

  logic        clk;
  logic        reset;
  logic        enable;
  logic [1:0]  mode;
  logic [31:0] d32;
  logic [7:0]  d8;
  logic [31:0] q32;
  logic [7:0]  q8;
  logic        rco32, ld32, rco8, ld8;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [31:0] m_q32, m_q8;
  logic        m_r32, m_l32, m_r8, m_l8;

  counter_nx #(.NIBBLES(8), .SATURATE(1'b0)) u_wrap (
    .clk(clk), .reset(reset), .enable(enable), .mode(mode),
    .D(d32), .Q(q32), .rco(rco32), .load(ld32)
  );

  counter_nx #(.NIBBLES(2), .SATURATE(1'b1)) u_sat (
    .clk(clk), .reset(reset), .enable(enable), .mode(mode),
    .D(d8), .Q(q8), .rco(rco8), .load(ld8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain integer arithmetic on a w-bit counter.
  task automatic model_next(input logic [31:0] q, input int w, input bit sat,
                            input logic [31:0] d, output logic [31:0] nq,
                            output logic nr, output logic nl);
    logic [63:0] maxv;
    logic [63:0] s;
    maxv = (64'd1 << w) - 64'd1;
    nq = q; nr = 1'b0; nl = 1'b0;
    if (enable) begin
      if (mode == 2'b11) begin
        nq = d & maxv[31:0];
        nl = 1'b1;
      end else if (mode == 2'b01) begin
        if (q == 32'd0) begin
          nr = 1'b1;
          nq = sat ? 32'd0 : maxv[31:0];
        end else begin
          nq = q - 32'd1;
        end
      end else begin
        s = {32'd0, q} + ((mode == 2'b00) ? 64'd1 : 64'd3);
        if (s > maxv) begin
          nr = 1'b1;
          s  = sat ? maxv : (s - maxv - 64'd1);
        end
        nq = s[31:0];
      end
    end
  endtask

  task automatic tick();
    logic [31:0] nq32, nq8;
    logic        nr32, nl32, nr8, nl8;
    model_next(m_q32, 32, 1'b0, d32, nq32, nr32, nl32);
    model_next(m_q8, 8, 1'b1, {24'd0, d8}, nq8, nr8, nl8);
    @(posedge clk);
    #1;
    m_q32 = nq32; m_r32 = nr32; m_l32 = nl32;
    m_q8  = nq8;  m_r8  = nr8;  m_l8  = nl8;
    $display("t=%0t en=%b mode=%b q32=%h rco=%b ld=%b q8=%h rco8=%b ld8=%b",
             $time, enable, mode, q32, rco32, ld32, q8, rco8, ld8);
  endtask

  task automatic load32(input logic [31:0] v);
    enable = 1'b1; mode = 2'b11; d32 = v;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b0; enable = 1'b1; mode = 2'b00; d32 = '0; d8 = '0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({q32, rco32, ld32, q8, rco8, ld8} !== 44'd0) begin
      n_fail++;
      $display("FAIL reset got q32=%h rco=%b ld=%b q8=%h rco8=%b ld8=%b want all 0",
               q32, rco32, ld32, q8, rco8, ld8);
    end
    m_q32 = '0; m_r32 = 0; m_l32 = 0; m_q8 = '0; m_r8 = 0; m_l8 = 0;
    reset = 1'b1;
  endtask

  task automatic test_load();
    enable = 1'b1; mode = 2'b11; d32 = 32'h1234_5678; d8 = 8'h5A;
    tick();
    n_cmp++;
    if ({q32, rco32, ld32} !== {32'h1234_5678, 1'b0, 1'b1}) begin
      n_fail++; $display("FAIL load got %h/%b/%b want 12345678/0/1", q32, rco32, ld32);
    end
    n_cmp++;
    if ({q8, ld8} !== {8'h5A, 1'b1}) begin
      n_fail++; $display("FAIL load8 got %h/%b want 5a/1", q8, ld8);
    end
    mode = 2'b00;
    tick();
    n_cmp++;
    if ({q32, rco32, ld32} !== {32'h1234_5679, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL load_then_up got %h/%b/%b want 12345679/0/0", q32, rco32, ld32);
    end
  endtask

  task automatic test_up_wrap();
    load32(32'hFFFF_FFFE);
    mode = 2'b00;
    tick();
    n_cmp++;
    if ({q32, rco32} !== {32'hFFFF_FFFF, 1'b0}) begin
      n_fail++; $display("FAIL up_to_max got %h/%b want ffffffff/0", q32, rco32);
    end
    tick();
    n_cmp++;
    if ({q32, rco32} !== {32'h0, 1'b1}) begin
      n_fail++; $display("FAIL up_wrap got %h/%b want 00000000/1", q32, rco32);
    end
    tick();
    n_cmp++;
    if ({q32, rco32} !== {32'h1, 1'b0}) begin
      n_fail++; $display("FAIL after_wrap got %h/%b want 00000001/0", q32, rco32);
    end
  endtask

  task automatic test_step3();
    load32(32'h0000_000E);
    mode = 2'b10;
    tick();
    n_cmp++;
    if ({q32, rco32} !== {32'h11, 1'b0}) begin
      n_fail++; $display("FAIL up3_carry got %h/%b want 00000011/0", q32, rco32);
    end
    load32(32'hFFFF_FFFE);
    mode = 2'b10;
    tick();
    n_cmp++;
    if ({q32, rco32} !== {32'h1, 1'b1}) begin
      n_fail++; $display("FAIL up3_wrap got %h/%b want 00000001/1", q32, rco32);
    end
  endtask

  task automatic test_down_borrow();
    load32(32'h0000_0100);
    mode = 2'b01;
    tick();
    n_cmp++;
    if ({q32, rco32} !== {32'hFF, 1'b0}) begin
      n_fail++; $display("FAIL dn_borrow got %h/%b want 000000ff/0", q32, rco32);
    end
    load32(32'h0);
    mode = 2'b01;
    tick();
    n_cmp++;
    if ({q32, rco32} !== {32'hFFFF_FFFF, 1'b1}) begin
      n_fail++; $display("FAIL dn_wrap got %h/%b want ffffffff/1", q32, rco32);
    end
  endtask

  task automatic test_saturate();
    enable = 1'b1; mode = 2'b11; d8 = 8'hFD;
    tick();
    mode = 2'b10;
    tick();
    n_cmp++;
    if ({q8, rco8} !== {8'hFF, 1'b1}) begin
      n_fail++; $display("FAIL sat_up3 got %h/%b want ff/1", q8, rco8);
    end
    tick();
    n_cmp++;
    if ({q8, rco8} !== {8'hFF, 1'b1}) begin
      n_fail++; $display("FAIL sat_at_max got %h/%b want ff/1", q8, rco8);
    end
    mode = 2'b11; d8 = 8'h00;
    tick();
    mode = 2'b01;
    tick();
    n_cmp++;
    if ({q8, rco8} !== {8'h00, 1'b1}) begin
      n_fail++; $display("FAIL sat_dn got %h/%b want 00/1", q8, rco8);
    end
    mode = 2'b00;
    tick();
    n_cmp++;
    if ({q8, rco8} !== {8'h01, 1'b0}) begin
      n_fail++; $display("FAIL sat_up1 got %h/%b want 01/0", q8, rco8);
    end
  endtask

  task automatic test_hold();
    enable = 1'b1; mode = 2'b11; d32 = 32'hA5A5_0003; d8 = 8'h10;
    tick();
    enable = 1'b0; mode = 2'b00;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if ({q32, rco32, ld32, q8, ld8} !== {32'hA5A5_0003, 1'b0, 1'b0, 8'h10, 1'b0}) begin
        n_fail++;
        $display("FAIL hold%0d got %h/%b/%b q8=%h ld8=%b want a5a50003/0/0 q8=10 ld8=0",
                 i, q32, rco32, ld32, q8, ld8);
      end
    end
  endtask

  task automatic test_async_reset();
    enable = 1'b1; mode = 2'b00;
    tick();
    tick();
    #2;
    reset = 1'b0;
    #1;
    n_cmp++;
    if ({q32, rco32, ld32, q8} !== {32'h0, 1'b0, 1'b0, 8'h0}) begin
      n_fail++; $display("FAIL async_reset got q32=%h rco=%b ld=%b q8=%h want 0", q32, rco32, ld32, q8);
    end
    m_q32 = '0; m_r32 = 0; m_l32 = 0; m_q8 = '0; m_r8 = 0; m_l8 = 0;
    #3;
    reset = 1'b1;
    tick();
    n_cmp++;
    if ({q32, rco32, ld32, q8} !== {32'h1, 1'b0, 1'b0, 8'h1}) begin
      n_fail++; $display("FAIL resume got q32=%h rco=%b ld=%b q8=%h want 1/0/0/01", q32, rco32, ld32, q8);
    end
  endtask

  task automatic test_random();
    int sel;
    for (int i = 0; i < 400; i++) begin
      enable = ($urandom_range(0, 7) != 0);
      mode   = 2'($urandom_range(0, 3));
      sel    = $urandom_range(0, 3);
      d32 = (sel == 0) ? 32'hFFFF_FFFF - $urandom_range(0, 3) :
            (sel == 1) ? 32'($urandom_range(0, 3)) : $urandom;
      d8  = (sel == 0) ? 8'hFF - 8'($urandom_range(0, 3)) :
            (sel == 1) ? 8'($urandom_range(0, 3)) : 8'($urandom);
      tick();
      n_cmp++;
      if ({q32, rco32, ld32} !== {m_q32, m_r32, m_l32}) begin
        n_fail++; $display("FAIL rand32 cyc%0d got %h/%b/%b want %h/%b/%b",
                           i, q32, rco32, ld32, m_q32, m_r32, m_l32);
      end
      n_cmp++;
      if ({q8, rco8, ld8} !== {m_q8[7:0], m_r8, m_l8}) begin
        n_fail++; $display("FAIL rand8 cyc%0d got %h/%b/%b want %h/%b/%b",
                           i, q8, rco8, ld8, m_q8[7:0], m_r8, m_l8);
      end
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_up_wrap();
    test_step3();
    test_down_borrow();
    test_saturate();
    test_hold();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
